// File: rtl/param_combo_lock_if.sv
// Keypad-lock bus: groups the keypad inputs and the display/status outputs
// of param_combo_lock so that board top level and testbench connect through
// a single bundle.
//
//   digit_in  : candidate BCD digit (valid iff <= 9)
//   enter     : single-cycle strobe submitting digit_in
//   relock    : level, return to code entry
//   prog      : level, request code reprogramming while open
//   hex0..5   : active-low segments {g,f,e,d,c,b,a}, hex0 rightmost
//   is_open   : lock is open
//   lockout   : lock is in timed lockout
//   fail_cnt  : consecutive failed attempts
//   digit_idx : digits accepted in the current attempt / program pass
//
// master drives the keypad side (board top or testbench), slave is the lock.
interface param_combo_lock_if #(
  parameter int MAX_FAILS = 3
);
  localparam int FW = $clog2(MAX_FAILS + 1);

  logic [3:0]    digit_in;
  logic          enter;
  logic          relock;
  logic          prog;
  logic [6:0]    hex0;
  logic [6:0]    hex1;
  logic [6:0]    hex2;
  logic [6:0]    hex3;
  logic [6:0]    hex4;
  logic [6:0]    hex5;
  logic          is_open;
  logic          lockout;
  logic [FW-1:0] fail_cnt;
  logic [2:0]    digit_idx;

  modport master (
    output digit_in, enter, relock, prog,
    input  hex0, hex1, hex2, hex3, hex4, hex5,
    input  is_open, lockout, fail_cnt, digit_idx
  );

  modport slave (
    input  digit_in, enter, relock, prog,
    output hex0, hex1, hex2, hex3, hex4, hex5,
    output is_open, lockout, fail_cnt, digit_idx
  );
endinterface

// File: rtl/param_combo_lock.sv
// Parametrised keypad combination lock with six 7-segment displays.
//
// Digits are taken one per enter strobe. A full attempt always consumes
// N_DIGITS digits (no early exit on a wrong digit, so timing leaks nothing).
// MAX_FAILS consecutive failed attempts force a lockout lasting exactly
// LOCKOUT_CYCLES clocks, which only rst can cut short. While open, the code
// can be rewritten through a shadow register that is committed only after a
// complete program pass, so an aborted pass leaves the old code intact.
//
// Ports:
//   clk  : system clock, all state updates on posedge
//   rst  : synchronous active-high reset
//   bus  : param_combo_lock_if.slave (keypad inputs, displays, status)
module param_combo_lock #(
  parameter int          N_DIGITS       = 6,
  parameter logic [23:0] DEFAULT_CODE   = 24'h722297,
  parameter int          MAX_FAILS      = 3,
  parameter int          LOCKOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  param_combo_lock_if.slave bus
);

  localparam int FW = $clog2(MAX_FAILS + 1);
  localparam int TW = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [2:0]    IDX_LAST   = 3'(N_DIGITS - 1);
  localparam logic [FW-1:0] FAIL_LAST  = FW'(MAX_FAILS - 1);
  localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_FAILS);
  localparam logic [TW-1:0] TIMER_INIT = TW'(LOCKOUT_CYCLES);

  // Segment glyphs, active low, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [6:0] SEG_E   = 7'b0000110;
  localparam logic [6:0] SEG_R   = 7'b0101111;
  localparam logic [6:0] SEG_O   = 7'b1000000;
  localparam logic [6:0] SEG_P   = 7'b0001100;
  localparam logic [6:0] SEG_N   = 7'b0101011;
  localparam logic [6:0] SEG_C   = 7'b1000110;
  localparam logic [6:0] SEG_L   = 7'b1000111;
  localparam logic [6:0] SEG_S   = 7'b0010010;
  localparam logic [6:0] SEG_D   = 7'b1000000;

  typedef enum logic [2:0] {
    ST_ENTRY   = 3'd0,
    ST_CLOSED  = 3'd1,
    ST_OPEN    = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_PROGRAM = 3'd4
  } state_t;

  state_t        state_q,     state_d;
  logic [2:0]    digit_idx_q, digit_idx_d;
  logic          mismatch_q,  mismatch_d;
  logic [FW-1:0] fail_cnt_q,  fail_cnt_d;
  logic [TW-1:0] timer_q,     timer_d;
  logic [23:0]   code_q,      code_d;
  logic [23:0]   shadow_q,    shadow_d;
  logic          is_open_q,   is_open_d;
  logic          lockout_q,   lockout_d;

  logic          digit_ok;
  logic          accept;
  logic          last_digit;
  logic          mismatch_now;
  logic [23:0]   shadow_wr;

  // Nibble position of entry index i: index 0 is the most significant used
  // nibble, so the code reads left to right in the order it is typed.
  function automatic int digit_pos(input logic [2:0] i);
    int p;
    p = N_DIGITS - 1 - int'(i);
    return (p < 0) ? 0 : p;
  endfunction

  function automatic logic [3:0] get_digit(input logic [23:0] c, input logic [2:0] i);
    logic [23:0] s;
    s = c >> (4 * digit_pos(i));
    return s[3:0];
  endfunction

  function automatic logic [23:0] set_digit(input logic [23:0] c, input logic [2:0] i,
                                            input logic [3:0] d);
    int sh;
    sh = 4 * digit_pos(i);
    return (c & ~(24'hF << sh)) | ({20'd0, d} << sh);
  endfunction

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return SEG_OFF;
    endcase
  endfunction

  assign digit_ok   = (bus.digit_in <= 4'd9);
  assign accept     = bus.enter && digit_ok;
  assign last_digit = (digit_idx_q == IDX_LAST);

  // Next-state logic. Priority inside each state: relock > prog > enter.
  always_comb begin
    state_d      = state_q;
    digit_idx_d  = digit_idx_q;
    mismatch_d   = mismatch_q;
    fail_cnt_d   = fail_cnt_q;
    timer_d      = timer_q;
    code_d       = code_q;
    shadow_d     = shadow_q;
    mismatch_now = mismatch_q | (bus.digit_in != get_digit(code_q, digit_idx_q));
    shadow_wr    = set_digit(shadow_q, digit_idx_q, bus.digit_in);

    case (state_q)
      ST_ENTRY: begin
        if (bus.relock) begin
          digit_idx_d = 3'd0;
          mismatch_d  = 1'b0;
        end else if (accept) begin
          if (last_digit) begin
            digit_idx_d = 3'd0;
            mismatch_d  = 1'b0;
            if (!mismatch_now) begin
              state_d    = ST_OPEN;
              fail_cnt_d = '0;
            end else if (fail_cnt_q == FAIL_LAST) begin
              state_d    = ST_LOCKOUT;
              timer_d    = TIMER_INIT;
              fail_cnt_d = FAIL_MAX;
            end else begin
              state_d    = ST_CLOSED;
              fail_cnt_d = fail_cnt_q + 1'b1;
            end
          end else begin
            digit_idx_d = digit_idx_q + 3'd1;
            mismatch_d  = mismatch_now;
          end
        end
      end

      ST_CLOSED: begin
        // Any enter, even an invalid digit, just acknowledges the failure.
        if (bus.relock) begin
          state_d     = ST_ENTRY;
          digit_idx_d = 3'd0;
          mismatch_d  = 1'b0;
        end else if (bus.enter) begin
          state_d = ST_ENTRY;
        end
      end

      ST_OPEN: begin
        if (bus.relock) begin
          state_d = ST_ENTRY;
        end else if (bus.prog) begin
          state_d     = ST_PROGRAM;
          digit_idx_d = 3'd0;
          shadow_d    = code_q;
        end
      end

      ST_PROGRAM: begin
        if (bus.relock) begin
          state_d     = ST_ENTRY;
          digit_idx_d = 3'd0;
        end else if (accept) begin
          shadow_d = shadow_wr;
          if (last_digit) begin
            code_d      = shadow_wr;
            digit_idx_d = 3'd0;
            state_d     = ST_ENTRY;
          end else begin
            digit_idx_d = digit_idx_q + 3'd1;
          end
        end
      end

      ST_LOCKOUT: begin
        // Exit on timer==1 so the state is held for exactly TIMER_INIT
        // cycles; a zero timer can only arise from corruption and also exits.
        timer_d = timer_q - 1'b1;
        if (timer_q <= TW'(1)) begin
          state_d    = ST_ENTRY;
          fail_cnt_d = '0;
          timer_d    = '0;
        end
      end

      default: begin
        state_d     = ST_ENTRY;
        digit_idx_d = 3'd0;
        mismatch_d  = 1'b0;
      end
    endcase

    is_open_d = (state_d == ST_OPEN);
    lockout_d = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ENTRY;
      digit_idx_q <= 3'd0;
      mismatch_q  <= 1'b0;
      fail_cnt_q  <= '0;
      timer_q     <= '0;
      code_q      <= DEFAULT_CODE;
      shadow_q    <= 24'd0;
      is_open_q   <= 1'b0;
      lockout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      digit_idx_q <= digit_idx_d;
      mismatch_q  <= mismatch_d;
      fail_cnt_q  <= fail_cnt_d;
      timer_q     <= timer_d;
      code_q      <= code_d;
      shadow_q    <= shadow_d;
      is_open_q   <= is_open_d;
      lockout_q   <= lockout_d;
    end
  end

  // Display: combinational from the current state and the live digit_in so
  // the user sees the digit before pressing enter.
  always_comb begin
    bus.hex0 = SEG_OFF;
    bus.hex1 = SEG_OFF;
    bus.hex2 = SEG_OFF;
    bus.hex3 = SEG_OFF;
    bus.hex4 = SEG_OFF;
    bus.hex5 = SEG_OFF;
    case (state_q)
      ST_ENTRY, ST_PROGRAM: begin
        if (state_q == ST_PROGRAM) bus.hex5 = SEG_P;
        if (digit_ok) begin
          bus.hex0 = seg_digit(bus.digit_in);
        end else begin
          bus.hex4 = SEG_E;
          bus.hex3 = SEG_R;
          bus.hex2 = SEG_R;
          bus.hex1 = SEG_O;
          bus.hex0 = SEG_R;
        end
      end
      ST_CLOSED: begin
        bus.hex5 = SEG_C;
        bus.hex4 = SEG_L;
        bus.hex3 = SEG_O;
        bus.hex2 = SEG_S;
        bus.hex1 = SEG_E;
        bus.hex0 = SEG_D;
      end
      ST_OPEN: begin
        bus.hex3 = SEG_O;
        bus.hex2 = SEG_P;
        bus.hex1 = SEG_E;
        bus.hex0 = SEG_N;
      end
      ST_LOCKOUT: begin
        bus.hex2 = SEG_L;
        bus.hex1 = SEG_O;
        bus.hex0 = SEG_C;
      end
      default: ;
    endcase
  end

  assign bus.is_open   = is_open_q;
  assign bus.lockout   = lockout_q;
  assign bus.fail_cnt  = fail_cnt_q;
  assign bus.digit_idx = digit_idx_q;

endmodule
